// File: rtl/wrr_prio_table_if.sv
// Interface bundle for the WRR weight table / credit engine.
// master = software+arbiter side, slave = wrr_prio_table.
interface wrr_prio_table_if #(
  parameter int NUM_REQ = 24,
  parameter int ID_W    = 5,
  parameter int PRIO_W  = 4
);
  logic               prio_upt;
  logic [ID_W-1:0]    prio_id;
  logic [PRIO_W-1:0]  prio;
  logic               commit;
  logic [NUM_REQ-1:0] req;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] eligible;
  logic               round_start;
  logic               commit_pend;
  logic               upt_err;
  logic               grant_err;

  modport master (
    output prio_upt, prio_id, prio, commit,
    output req, grant_vld, grant_id,
    input  eligible, round_start, commit_pend,
    input  upt_err, grant_err
  );

  modport slave (
    input  prio_upt, prio_id, prio, commit,
    input  req, grant_vld, grant_id,
    output eligible, round_start, commit_pend,
    output upt_err, grant_err
  );
endinterface

// File: rtl/wrr_prio_table.sv
// WRR weight store: shadow/active weight tables and per-requester credits.
// Ports: clk, rst (async active-low), bus (slave: writes, commit, req, grants -> eligible, status pulses).
module wrr_prio_table #(
  parameter int NUM_REQ      = 24,
  parameter int ID_W         = 5,
  parameter int PRIO_W       = 4,
  parameter int DEFAULT_PRIO = 1
) (
  input logic          clk,
  input logic          rst,
  wrr_prio_table_if.slave bus
);
  localparam logic [ID_W:0]     LP_NREQ = (ID_W+1)'(NUM_REQ);
  localparam logic [PRIO_W-1:0] LP_DEF  = PRIO_W'(DEFAULT_PRIO);
  localparam logic [PRIO_W-1:0] LP_ONE  = PRIO_W'(1);

  logic [PRIO_W-1:0] r_shadow [NUM_REQ];
  logic [PRIO_W-1:0] r_active [NUM_REQ];
  logic [PRIO_W-1:0] r_credit [NUM_REQ];
  logic              r_pend;
  logic              r_rs;
  logic              r_uerr;
  logic              r_gerr;

  logic [NUM_REQ-1:0] w_nz;
  logic [NUM_REQ-1:0] w_hit;
  logic [NUM_REQ-1:0] w_elig;
  logic               w_reload;
  logic               w_upt_ok;
  logic               w_gnt_ok;
  logic               w_apply;

  always_comb begin
    w_nz  = '0;
    w_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_nz[i]  = (r_credit[i] != '0);
      w_hit[i] = (bus.grant_id == ID_W'(i));
    end
  end

  assign w_elig   = bus.req & w_nz;
  assign w_reload = ~|w_elig;
  assign w_apply  = w_reload & r_pend;
  assign w_upt_ok = ({1'b0, bus.prio_id} < LP_NREQ);
  // Out-of-range ids never hit; a reload cycle has no valid grant.
  assign w_gnt_ok = bus.grant_vld & ~w_reload & |(w_hit & w_nz);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_shadow[i] <= LP_DEF;
        r_active[i] <= LP_DEF;
        r_credit[i] <= LP_DEF;
      end
      r_pend <= 1'b0;
      r_rs   <= 1'b0;
      r_uerr <= 1'b0;
      r_gerr <= 1'b0;
    end else begin
      r_rs   <= w_reload;
      r_uerr <= bus.prio_upt & ~w_upt_ok;
      r_gerr <= bus.grant_vld & ~w_gnt_ok;
      // A commit arriving on the applying boundary merges into it.
      if (w_apply)
        r_pend <= 1'b0;
      else if (bus.commit)
        r_pend <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.prio_upt && bus.prio_id == ID_W'(i))
          r_shadow[i] <= bus.prio;
        if (w_apply)
          r_active[i] <= r_shadow[i];
        if (w_reload)
          r_credit[i] <= r_pend ? r_shadow[i] : r_active[i];
        else if (w_gnt_ok && w_hit[i])
          r_credit[i] <= r_credit[i] - LP_ONE;
      end
    end
  end

  assign bus.eligible    = w_elig;
  assign bus.round_start = r_rs;
  assign bus.commit_pend = r_pend;
  assign bus.upt_err     = r_uerr;
  assign bus.grant_err   = r_gerr;
endmodule

// File: tb/tb_wrr_prio_table.sv
// Self-checking bench for wrr_prio_table.
// Directed tables, corner sequences and random traffic vs a weight/credit model.
module tb_wrr_prio_table;
  localparam int N  = 24;
  localparam int IW = 5;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wrr_prio_table_if #(.NUM_REQ(N), .ID_W(IW), .PRIO_W(PW)) bus ();

  wrr_prio_table #(
    .NUM_REQ(N), .ID_W(IW), .PRIO_W(PW), .DEFAULT_PRIO(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  int m_sh [N];
  int m_act[N];
  int m_cr [N];
  bit m_pend, m_rs, m_ue, m_ge;

  typedef struct {
    bit          upt;
    int          pid;
    int          pr;
    bit          gv;
    int          gid;
    logic [N-1:0] elig;
    bit          ue;
    bit          ge;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] m_mask();
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++)
      m[i] = bus.req[i] && (m_cr[i] > 0);
    return m;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_sh[i] = 1; m_act[i] = 1; m_cr[i] = 1;
    end
    m_pend = 0; m_rs = 0; m_ue = 0; m_ge = 0;
  endtask

  task automatic m_step();
    bit reload, gok;
    int gid, pid;
    reload = (m_mask() == '0);
    gid = int'(bus.grant_id);
    pid = int'(bus.prio_id);
    gok = bus.grant_vld && !reload && gid < N;
    if (gok) gok = m_cr[gid] > 0;
    m_ue = bus.prio_upt && pid >= N;
    m_ge = bus.grant_vld && !gok;
    if (reload) begin
      if (m_pend) begin
        m_act = m_sh;
        m_cr  = m_sh;
      end else begin
        m_cr = m_act;
      end
    end else if (gok) begin
      m_cr[gid] = m_cr[gid] - 1;
    end
    if (reload && m_pend) m_pend = 0;
    else if (bus.commit) m_pend = 1;
    if (bus.prio_upt && pid < N) m_sh[pid] = int'(bus.prio);
    m_rs = reload;
  endtask

  task automatic idle_in();
    bus.prio_upt  = 1'b0;
    bus.prio_id   = '0;
    bus.prio      = '0;
    bus.commit    = 1'b0;
    bus.grant_vld = 1'b0;
    bus.grant_id  = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("eligible", 32'(bus.eligible), 32'(m_mask()));
    chk("round_start", 32'(bus.round_start), 32'(m_rs));
    chk("commit_pend", 32'(bus.commit_pend), 32'(m_pend));
    chk("upt_err", 32'(bus.upt_err), 32'(m_ue));
    chk("grant_err", 32'(bus.grant_err), 32'(m_ge));
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_in();
    bus.req = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic write(int id, int p, bit cm);
    bus.prio_upt = 1'b1;
    bus.prio_id  = IW'(id);
    bus.prio     = PW'(p);
    bus.commit   = cm;
    cyc();
    idle_in();
  endtask

  task automatic grant(int id);
    bus.grant_vld = 1'b1;
    bus.grant_id  = IW'(id);
    cyc();
    idle_in();
  endtask

  task automatic count_grants(int id, output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.eligible[id]) break;
      grant(id);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    idle_in();
    bus.req = '0;

    tbl[0] = '{1, 24, 9, 0, 0,  24'hFFFFFF, 1, 0};
    tbl[1] = '{0, 0,  0, 1, 30, 24'hFFFFFF, 0, 1};
    tbl[2] = '{0, 0,  0, 1, 0,  24'hFFFFFF, 0, 0};
    tbl[3] = '{0, 0,  0, 1, 0,  24'hFFFFFE, 0, 1};
    tbl[4] = '{0, 0,  0, 1, 1,  24'hFFFFFE, 0, 0};
    tbl[5] = '{0, 0,  0, 0, 0,  24'hFFFFFC, 0, 0};

    // Basic round: one grant per id drains, then reload.
    do_reset();
    bus.req = '1;
    #1;
    chk("reset_elig", 32'(bus.eligible), 32'h00FFFFFF);
    for (int i = 0; i < N; i++) grant(i);
    chk("drained_elig", 32'(bus.eligible), 32'h0);
    cyc();
    chk("rs_after_drain", 32'(bus.round_start), 32'h1);
    chk("reload_elig", 32'(bus.eligible), 32'h00FFFFFF);

    // Error table.
    do_reset();
    bus.req = '1;
    for (int v = 0; v < 6; v++) begin
      bus.prio_upt  = tbl[v].upt;
      bus.prio_id   = IW'(tbl[v].pid);
      bus.prio      = PW'(tbl[v].pr);
      bus.grant_vld = tbl[v].gv;
      bus.grant_id  = IW'(tbl[v].gid);
      #1;
      chk("tbl_elig", 32'(bus.eligible), 32'(tbl[v].elig));
      cyc();
      idle_in();
      chk("tbl_upt_err", 32'(bus.upt_err), 32'(tbl[v].ue));
      chk("tbl_grant_err", 32'(bus.grant_err), 32'(tbl[v].ge));
    end

    // Commit weight 5 to id 3.
    do_reset();
    bus.req = '1;
    write(3, 5, 1'b1);
    chk("pend_set", 32'(bus.commit_pend), 32'h1);
    for (int i = 0; i < N; i++) grant(i);
    cyc();
    chk("pend_clr", 32'(bus.commit_pend), 32'h0);
    count_grants(3, n);
    chk("id3_w5", 32'(n), 32'd5);
    count_grants(0, n);
    chk("id0_w1", 32'(n), 32'd1);

    // Uncommitted write has no effect on rounds.
    do_reset();
    bus.req = N'(1) << 3;
    write(3, 7, 1'b0);
    for (int r = 0; r < 3; r++) begin
      count_grants(3, n);
      chk("nocommit_cnt", 32'(n), 32'd1);
      cyc();
      chk("nocommit_pend", 32'(bus.commit_pend), 32'h0);
    end

    // Write on the applying boundary lands in shadow only.
    do_reset();
    bus.req = N'(1) << 2;
    write(2, 3, 1'b1);
    grant(2);
    write(2, 4, 1'b0);
    count_grants(2, n);
    chk("bnd_old_val", 32'(n), 32'd3);
    cyc();
    bus.commit = 1'b1;
    cyc();
    idle_in();
    count_grants(2, n);
    chk("bnd_pending", 32'(n), 32'd3);
    cyc();
    count_grants(2, n);
    chk("bnd_new_val", 32'(n), 32'd4);

    // All-zero weights, recovery, then async reset mid-round.
    do_reset();
    for (int i = 0; i < N; i++) write(i, 0, 1'b0);
    bus.commit = 1'b1;
    cyc();
    idle_in();
    cyc();
    bus.req = '1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("zero_rs", 32'(bus.round_start), 32'h1);
      chk("zero_elig", 32'(bus.eligible), 32'h0);
    end
    write(0, 2, 1'b1);
    cyc();
    count_grants(0, n);
    chk("zero_recover", 32'(n), 32'd2);
    cyc();
    grant(0);
    #2;
    rst = 1'b0;
    #1;
    m_reset();
    chk("async_rst_elig", 32'(bus.eligible), 32'h00FFFFFF);
    chk("async_rst_rs", 32'(bus.round_start), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(999) == 0) do_reset();
      bus.prio_upt  = ($urandom_range(99) < 30);
      bus.prio_id   = IW'($urandom_range(31));
      bus.prio      = PW'($urandom_range(15));
      bus.commit    = ($urandom_range(99) < 10);
      bus.req       = ($urandom_range(9) == 0) ? '0 : N'($urandom);
      bus.grant_vld = ($urandom_range(99) < 60);
      bus.grant_id  = ($urandom_range(9) < 7) ?
                      IW'($urandom_range(N-1)) : IW'($urandom_range(31));
      cyc();
    end
    idle_in();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wrr_prio_table.md
# wrr_prio_table

Parametrised weight store and credit engine for the weighted round-robin arbiter. Software-side priority updates (`prio_upt`/`prio_id`/`prio`) land in a shadow table. A commit request copies the whole shadow table into the active table atomically at the next round boundary. Per-requester credit counters are reloaded from the active table each round, decremented on grants, and used to produce the arbiter's `eligible` mask.

## Interface
- `NUM_REQ`, default 24: number of requesters; must satisfy 1 ≤ NUM_REQ ≤ 2**ID_W.
- `ID_W`, default 5: width of `prio_id` and `grant_id`.
- `PRIO_W`, default 4: weight and credit width; weight 0 disables a requester.
- `DEFAULT_PRIO`, default 1: reset value of every shadow weight, active weight and credit.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `prio_upt` in 1: shadow write strobe.
- `prio_id` in ID_W: requester index for the write.
- `prio` in PRIO_W: new weight for the write.
- `commit` in 1: request a shadow→active copy at the next round boundary.
- `req` in NUM_REQ: requester request vector.
- `grant_vld` in 1: arbiter issued a grant this cycle.
- `grant_id` in ID_W: index of the granted requester.
- `eligible` out NUM_REQ: combinational, `req[i] & (credit[i] != 0)`.
- `round_start` out 1: registered one-cycle pulse, credits were reloaded on the previous edge.
- `commit_pend` out 1: registered, a commit is waiting for a boundary.
- `upt_err` out 1: registered one-cycle pulse, the last write had `prio_id` ≥ NUM_REQ.
- `grant_err` out 1: registered one-cycle pulse, the last grant was invalid.

## Operation
- Reset (`rst`=0, asynchronous):
  - shadow[i], active[i] and credit[i] = DEFAULT_PRIO.
  - `commit_pend`, `round_start`, `upt_err` and `grant_err` = 0.
- Shadow write: `prio_upt`=1 with `prio_id` < NUM_REQ sets shadow[prio_id] = `prio` on the edge. With `prio_id` ≥ NUM_REQ the write is dropped and `upt_err`=1 on the next cycle. Active weights and credits are never touched by a write.
- Commit: `commit`=1 sets `commit_pend`. Repeated commits while pending are merged.
- Round boundary (reload) happens in any cycle where `eligible` == 0. On that edge:
  - If `commit_pend`: active ← shadow (pre-edge value), commit_pend ← 0, credit[i] ← shadow[i].
  - Otherwise credit[i] ← active[i].
  - `round_start`=1 in the following cycle.
- Grant: `grant_vld`=1 with `grant_id` < NUM_REQ and credit[grant_id] ≠ 0 decrements credit[grant_id] by 1. Credits saturate at 0 and never wrap.
  - A grant with `grant_id` ≥ NUM_REQ or zero credit is ignored, and `grant_err`=1 next cycle.
- Simultaneous events:
  - Write + reload with commit_pend: active receives the old shadow value. The new write stays in shadow only and needs a fresh commit.
  - `commit` + reload in the same cycle: if `commit_pend` was 0, the commit is not applied this boundary. `commit_pend` is 1 after the edge.
  - `grant_vld` + reload: a reload implies `eligible` == 0, so the grant is invalid. Reload wins and `grant_err` pulses.
  - Write + grant to the same id: independent. The shadow is written and the credit is decremented.
- All-zero active weights: `eligible` stays 0 and a reload occurs every cycle. `round_start` stays high until a committed nonzero weight arrives.
- Reset mid-round or mid-commit discards all pending state immediately.

## Timing
- Shadow write is visible internally 1 cycle after the strobe. It affects `eligible` only after commit + boundary, at the earliest 1 cycle after the boundary edge.
- `eligible` is combinational from the credit registers and `req`, with no registered latency.
- The minimum round length is 1 cycle.
- Error pulses and `round_start` are exactly 1 cycle wide and appear on the cycle after the causing edge.
- No backpressure: every write and commit is accepted every cycle.

## Test plan
- Reset then `req`=all ones: `eligible`=24'hFFFFFF. After 24 valid grants (one per id), `eligible`=0, the next cycle `round_start`=1, and credits are back to 1.
- Write id 3 = 5, then `commit`. Grant everyone to exhaustion. After the boundary, id 3 stays eligible for exactly 5 grants and the others for 1. `commit_pend` falls at the boundary edge.
- Write id 3 = 7 with no commit: across 3 rounds id 3 still accepts only 1 grant per round and `commit_pend`=0.
- Write `prio_id`=24, `prio`=9: `upt_err` pulses once and the shadow table is unchanged. A grant with `grant_id`=30, and a second grant to id 0 after its credit hits 0, each produce one `grant_err` pulse with no credit change.
- Boundary cycle with `commit_pend`=1 and a write to id 2 = 4 in the same cycle: active[2] takes the old shadow value. A later commit + boundary yields 4 grants for id 2.
- Commit all-zero weights: `eligible`=0 and `round_start` is high every cycle. Then write id 0 = 2, commit, and id 0 is eligible for 2 grants. Assert `rst` mid-round: all credits immediately = 1.
